// File: rtl/tmds_serializer_mc_if.sv
// Word handshake bundle for tmds_serializer_mc: one multi-lane word per transfer.
interface tmds_serializer_mc_if #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned WORD_W   = 10
);
  logic [CHANNELS*WORD_W-1:0] in_data;
  logic                       in_valid;
  logic                       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/tmds_serializer_mc.sv
// Multi-lane TMDS word serializer in the shift-clock domain. Words enter a small FIFO through
// a valid/ready handshake and leave LSB-first, BITS_PER_CLK bits per clock, toward external
// ODDR primitives. An empty FIFO at a load edge substitutes IDLE_WORD on every lane.
module tmds_serializer_mc #(
  parameter int unsigned       CHANNELS     = 3,
  parameter int unsigned       WORD_W       = 10,
  parameter int unsigned       BITS_PER_CLK = 2,
  parameter int unsigned       FIFO_DEPTH   = 4,
  parameter logic [WORD_W-1:0] IDLE_WORD    = WORD_W'(10'h354)
) (
  input  logic                               clk_shift,
  input  logic                               rst_n,
  tmds_serializer_mc_if.slave                bus,
  input  logic                               clear_underflow,
  output logic [CHANNELS-1:0]                out_d0,
  output logic [CHANNELS-1:0]                out_d1,
  output logic                               word_start,
  output logic                               underflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int unsigned K  = WORD_W / BITS_PER_CLK;
  localparam int unsigned PW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);

  localparam logic [PW-1:0] LastPhase = PW'(K - 1);
  localparam logic [LW-1:0] FullLevel = LW'(FIFO_DEPTH);

  // Lane i sits at [i*WORD_W +: WORD_W], matching the flat in_data layout.
  typedef logic [CHANNELS-1:0][WORD_W-1:0] lanes_t;

  lanes_t        mem_q [FIFO_DEPTH];
  lanes_t        shift_q, shift_d;
  lanes_t        head;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          primed_q, primed_d;
  logic          underflow_q, underflow_d;
  logic          load, empty, full, push, pop;

  // Handshake and load decode, all from registered state (no combinational ready path).
  always_comb begin
    empty = (count_q == '0);
    full  = (count_q == FullLevel);
    load  = (phase_q == LastPhase);
    push  = bus.in_valid && !full;
    pop   = load && !empty;
    head  = mem_q[rd_ptr_q];
  end

  // FIFO storage; contents need no reset since count_q gates every read.
  always_ff @(posedge clk_shift) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  // Next-state for phase, FIFO bookkeeping, lane shifters and status flags.
  always_comb begin
    phase_d     = load ? '0 : phase_q + PW'(1);
    wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d     = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase

    shift_d = shift_q;
    if (load) begin
      // A word written on this same edge is not visible yet: no bypass.
      shift_d = empty ? {CHANNELS{IDLE_WORD}} : head;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        shift_d[i] = shift_q[i] >> BITS_PER_CLK;
      end
    end

    primed_d    = primed_q | push;
    underflow_d = underflow_q;
    if (clear_underflow) begin
      underflow_d = 1'b0;
    end
    // Setting takes priority over a coincident clear.
    if (load && empty && primed_q) begin
      underflow_d = 1'b1;
    end
  end

  // State registers; reset parks the phase on a load so the first edge loads a word.
  always_ff @(posedge clk_shift or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      phase_q     <= LastPhase;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      primed_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      phase_q     <= phase_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      primed_q    <= primed_d;
      underflow_q <= underflow_d;
    end
  end

  // Output decode; with one bit per clock D0 and D1 carry the same bit (SDR through ODDR).
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      out_d0[i] = shift_q[i][0];
      out_d1[i] = shift_q[i][BITS_PER_CLK-1];
    end
    word_start   = (phase_q == '0);
    underflow    = underflow_q;
    fifo_level   = count_q;
    bus.in_ready = !full;
  end

endmodule

// File: tb/tb_tmds_serializer_mc.sv
// Directed bench for tmds_serializer_mc: a 2-bit/clk instance (dut2) and a 1-bit/clk one (dut1).
module tb_tmds_serializer_mc;

  logic clk_shift = 1'b0;
  always #5 clk_shift = ~clk_shift;

  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   n = 0;

  logic [9:0] idle_w = 10'h354;

  tmds_serializer_mc_if #(.CHANNELS(3), .WORD_W(10)) bus2 ();
  tmds_serializer_mc_if #(.CHANNELS(3), .WORD_W(10)) bus1 ();

  logic       clr2, clr1;
  logic [2:0] d0_2, d1_2, d0_1, d1_1;
  logic       ws2, ws1, uf2, uf1;
  logic [2:0] lvl2, lvl1;

  tmds_serializer_mc #(.CHANNELS(3), .WORD_W(10), .BITS_PER_CLK(2), .FIFO_DEPTH(4)) dut2 (
    .clk_shift       (clk_shift),
    .rst_n           (rst_n),
    .bus             (bus2),
    .clear_underflow (clr2),
    .out_d0          (d0_2),
    .out_d1          (d1_2),
    .word_start      (ws2),
    .underflow       (uf2),
    .fifo_level      (lvl2)
  );

  tmds_serializer_mc #(.CHANNELS(3), .WORD_W(10), .BITS_PER_CLK(1), .FIFO_DEPTH(4)) dut1 (
    .clk_shift       (clk_shift),
    .rst_n           (rst_n),
    .bus             (bus1),
    .clear_underflow (clr1),
    .out_d0          (d0_1),
    .out_d1          (d1_1),
    .word_start      (ws1),
    .underflow       (uf1),
    .fifo_level      (lvl1)
  );

  // Expected per-lane bit at position idx of a 3-lane word {lane2, lane1, lane0}.
  function automatic logic [2:0] lane_bits(input logic [29:0] w, input int idx);
    logic [9:0] a, b, c;
    a = w[9:0];
    b = w[19:10];
    c = w[29:20];
    return {c[idx], b[idx], a[idx]};
  endfunction

  task automatic step();
    @(posedge clk_shift);
    #1;
    n++;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus2.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    bus2.in_data  = '0;
    bus1.in_data  = '0;
    clr2          = 1'b0;
    clr1          = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b1;
    n     = 0;
  endtask

  task automatic test_reset();
    logic [29:0] idle3;
    int          b;
    idle3 = {idle_w, idle_w, idle_w};
    do_reset();
    rst_n = 1'b0;
    step();
    step();
    step();
    if (d0_2 !== 3'b000) begin errors++; $display("FAIL reset_d0 got=%b exp=000", d0_2); end
    checks++;
    if (d1_2 !== 3'b000) begin errors++; $display("FAIL reset_d1 got=%b exp=000", d1_2); end
    checks++;
    if (ws2 !== 1'b0) begin errors++; $display("FAIL reset_ws got=%b exp=0", ws2); end
    checks++;
    if (uf2 !== 1'b0) begin errors++; $display("FAIL reset_uf got=%b exp=0", uf2); end
    checks++;
    if (lvl2 !== 3'd0) begin errors++; $display("FAIL reset_lvl got=%0d exp=0", lvl2); end
    checks++;
    if (bus2.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready got=%b exp=1", bus2.in_ready);
    end
    checks++;
    rst_n = 1'b1;
    n     = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      b = (n - 1) % 5;
      if (d0_2 !== lane_bits(idle3, 2*b)) begin
        errors++; $display("FAIL reset_idle_d0 n=%0d got=%b exp=%b", n, d0_2, lane_bits(idle3, 2*b));
      end
      checks++;
      if (d1_2 !== lane_bits(idle3, 2*b+1)) begin
        errors++;
        $display("FAIL reset_idle_d1 n=%0d got=%b exp=%b", n, d1_2, lane_bits(idle3, 2*b+1));
      end
      checks++;
      if (ws2 !== (b == 0)) begin
        errors++; $display("FAIL reset_idle_ws n=%0d got=%b exp=%b", n, ws2, (b == 0));
      end
      checks++;
      if (uf2 !== 1'b0) begin errors++; $display("FAIL reset_idle_uf n=%0d got=%b exp=0", n, uf2); end
      checks++;
    end
  endtask

  task automatic test_single();
    logic [29:0] data, cur;
    int          b;
    data = {10'h3FF, 10'h155, 10'h2AB};
    do_reset();
    bus2.in_data  = data;
    bus2.in_valid = 1'b1;
    step();
    bus2.in_valid = 1'b0;
    if (lvl2 !== 3'd1) begin errors++; $display("FAIL single_lvl_after_write got=%0d exp=1", lvl2); end
    checks++;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) step();
      b   = (n - 1) % 5;
      cur = (n >= 6 && n <= 10) ? data : {idle_w, idle_w, idle_w};
      if (d0_2 !== lane_bits(cur, 2*b)) begin
        errors++; $display("FAIL single_d0 n=%0d got=%b exp=%b", n, d0_2, lane_bits(cur, 2*b));
      end
      checks++;
      if (d1_2 !== lane_bits(cur, 2*b+1)) begin
        errors++; $display("FAIL single_d1 n=%0d got=%b exp=%b", n, d1_2, lane_bits(cur, 2*b+1));
      end
      checks++;
      if (ws2 !== (b == 0)) begin
        errors++; $display("FAIL single_ws n=%0d got=%b exp=%b", n, ws2, (b == 0));
      end
      checks++;
      if (uf2 !== (n >= 11)) begin
        errors++; $display("FAIL single_uf n=%0d got=%b exp=%b", n, uf2, (n >= 11));
      end
      checks++;
    end
  endtask

  task automatic test_back_to_back();
    logic [29:0] bpw [5];
    logic [29:0] cur;
    int          b;
    bpw[0] = {10'h0F0, 10'h00F, 10'h3C3};
    bpw[1] = {10'h1A5, 10'h25A, 10'h001};
    bpw[2] = {10'h200, 10'h155, 10'h2AA};
    bpw[3] = {10'h333, 10'h0CC, 10'h3E1};
    bpw[4] = {10'h07E, 10'h381, 10'h118};
    do_reset();
    for (int c = 0; c < 31; c++) begin
      // Accepted edges are E1..E4 and E7 (the pop on E6 frees one slot).
      bus2.in_valid = (n <= 6);
      bus2.in_data  = bpw[(n < 4) ? n : 4];
      step();
      if (n == 4 || n == 5 || n == 7) begin
        if (lvl2 !== 3'd4) begin errors++; $display("FAIL bp_lvl_full n=%0d got=%0d exp=4", n, lvl2); end
        checks++;
        if (bus2.in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_ready_full n=%0d got=%b exp=0", n, bus2.in_ready);
        end
        checks++;
      end
      if (n == 6) begin
        if (lvl2 !== 3'd3) begin errors++; $display("FAIL bp_lvl_pop n=%0d got=%0d exp=3", n, lvl2); end
        checks++;
        if (bus2.in_ready !== 1'b1) begin
          errors++; $display("FAIL bp_ready_pop n=%0d got=%b exp=1", n, bus2.in_ready);
        end
        checks++;
      end
      b   = (n - 1) % 5;
      cur = (n >= 6 && n <= 30) ? bpw[(n-6)/5] : {idle_w, idle_w, idle_w};
      if (d0_2 !== lane_bits(cur, 2*b)) begin
        errors++; $display("FAIL bp_d0 n=%0d got=%b exp=%b", n, d0_2, lane_bits(cur, 2*b));
      end
      checks++;
      if (d1_2 !== lane_bits(cur, 2*b+1)) begin
        errors++; $display("FAIL bp_d1 n=%0d got=%b exp=%b", n, d1_2, lane_bits(cur, 2*b+1));
      end
      checks++;
      if (uf2 !== (n >= 31)) begin
        errors++; $display("FAIL bp_uf n=%0d got=%b exp=%b", n, uf2, (n >= 31));
      end
      checks++;
    end
  endtask

  task automatic test_simultaneous();
    logic [29:0] sw [3];
    sw[0] = {10'h111, 10'h222, 10'h0AB};
    sw[1] = {10'h3A0, 10'h05C, 10'h1E7};
    sw[2] = {10'h2D2, 10'h16B, 10'h009};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      // Writes land on E4, E5 and E6; E6 is also a load edge that pops.
      bus2.in_valid = (n >= 3 && n <= 5);
      bus2.in_data  = sw[(n >= 3 && n <= 5) ? n - 3 : 0];
      step();
      if (n == 5 || n == 6 || n == 7) begin
        if (lvl2 !== 3'd2) begin errors++; $display("FAIL simul_lvl n=%0d got=%0d exp=2", n, lvl2); end
        checks++;
      end
      if (n == 6) begin
        if (d0_2 !== lane_bits(sw[0], 0) || d1_2 !== lane_bits(sw[0], 1)) begin
          errors++;
          $display("FAIL simul_first_beat got=%b/%b exp=%b/%b", d0_2, d1_2,
                   lane_bits(sw[0], 0), lane_bits(sw[0], 1));
        end
        checks++;
      end
    end
    bus2.in_valid = 1'b0;
  endtask

  task automatic test_underflow_clear();
    logic exp_uf;
    do_reset();
    bus2.in_data  = {10'h123, 10'h234, 10'h345};
    bus2.in_valid = 1'b1;
    step();
    bus2.in_valid = 1'b0;
    while (n < 17) begin
      // E13 is a plain shift edge; E16 is an empty load edge.
      clr2 = (n == 12 || n == 15);
      step();
      clr2 = 1'b0;
      if (n >= 10) begin
        exp_uf = (n == 11 || n == 12 || n == 16 || n == 17);
        if (uf2 !== exp_uf) begin
          errors++; $display("FAIL uf_clear n=%0d got=%b exp=%b", n, uf2, exp_uf);
        end
        checks++;
      end
    end
  endtask

  task automatic test_bpc1();
    logic [9:0] cur;
    int         b;
    do_reset();
    bus1.in_data  = {10'h001, 10'h001, 10'h001};
    bus1.in_valid = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    for (int c = 0; c < 21; c++) begin
      if (c > 0) step();
      b   = (n - 1) % 10;
      cur = (n >= 11 && n <= 20) ? 10'h001 : idle_w;
      if (d0_1 !== {3{cur[b]}}) begin
        errors++; $display("FAIL bpc1_d0 n=%0d got=%b exp=%b", n, d0_1, {3{cur[b]}});
      end
      checks++;
      if (d1_1 !== {3{cur[b]}}) begin
        errors++; $display("FAIL bpc1_d1 n=%0d got=%b exp=%b", n, d1_1, {3{cur[b]}});
      end
      checks++;
      if (ws1 !== (b == 0)) begin
        errors++; $display("FAIL bpc1_ws n=%0d got=%b exp=%b", n, ws1, (b == 0));
      end
      checks++;
    end
    if (uf1 !== 1'b1) begin errors++; $display("FAIL bpc1_uf got=%b exp=1", uf1); end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic [29:0] idle3;
    int          b;
    idle3 = {idle_w, idle_w, idle_w};
    do_reset();
    bus2.in_valid = 1'b1;
    bus2.in_data  = {10'h2F0, 10'h0E1, 10'h1D2};
    step();
    step();
    step();
    bus2.in_valid = 1'b0;
    if (lvl2 !== 3'd3) begin errors++; $display("FAIL mid_lvl_before got=%0d exp=3", lvl2); end
    checks++;
    if (d0_2 !== 3'b111) begin errors++; $display("FAIL mid_d0_before got=%b exp=111", d0_2); end
    checks++;
    rst_n = 1'b0;
    #1;
    if (d0_2 !== 3'b000 || d1_2 !== 3'b000) begin
      errors++; $display("FAIL mid_out_async got=%b/%b exp=000/000", d0_2, d1_2);
    end
    checks++;
    if (lvl2 !== 3'd0) begin errors++; $display("FAIL mid_lvl_async got=%0d exp=0", lvl2); end
    checks++;
    if (ws2 !== 1'b0) begin errors++; $display("FAIL mid_ws_async got=%b exp=0", ws2); end
    checks++;
    if (bus2.in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_ready_async got=%b exp=1", bus2.in_ready);
    end
    checks++;
    step();
    step();
    rst_n = 1'b1;
    n     = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      b = (n - 1) % 5;
      if (d0_2 !== lane_bits(idle3, 2*b) || d1_2 !== lane_bits(idle3, 2*b+1)) begin
        errors++;
        $display("FAIL mid_idle n=%0d got=%b/%b exp=%b/%b", n, d0_2, d1_2,
                 lane_bits(idle3, 2*b), lane_bits(idle3, 2*b+1));
      end
      checks++;
      if (lvl2 !== 3'd0 || uf2 !== 1'b0) begin
        errors++; $display("FAIL mid_state n=%0d got lvl=%0d uf=%b exp lvl=0 uf=0", n, lvl2, uf2);
      end
      checks++;
    end
  endtask

  initial begin
    bus2.in_valid = 1'b0;
    bus1.in_valid = 1'b0;
    bus2.in_data  = '0;
    bus1.in_data  = '0;
    clr2          = 1'b0;
    clr1          = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_simultaneous();
    test_underflow_clear();
    test_bpc1();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
